// File: rtl/pool2_collector.sv
// Collects one frame of pooled samples (MAPS maps x PIX samples) into a flat buffer,
// then streams it out in index order over a valid/ready interface.
module pool2_collector #(
  parameter int DATA_W = 12,
  parameter int MAPS   = 12,
  parameter int PIX    = 9,
  parameter int RELU   = 1
) (
  input  logic                     cnn_clk,
  input  logic                     rst_n,
  input  logic                     buffer_en,
  input  logic signed [DATA_W-1:0] max,
  input  logic [3:0]               feature_map_counter,
  input  logic                     fc_ready,
  output logic                     fc_valid,
  output logic signed [DATA_W-1:0] fc_data,
  output logic [6:0]               fc_index,
  output logic                     fc_last,
  output logic                     collect_done,
  output logic                     map_err,
  output logic                     overflow_err
);
  localparam int         DEPTH    = MAPS * PIX;
  localparam logic [6:0] LAST_IDX = 7'(DEPTH - 1);
  localparam logic [6:0] PIX_LAST = 7'(PIX - 1);
  localparam logic [6:0] PIX_W7   = 7'(PIX);
  localparam logic [3:0] MAP_LAST = 4'(MAPS - 1);

  typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [6:0]               pix_q, pix_d;
  logic [3:0]               map_q, map_d;
  logic [6:0]               rd_idx_q, rd_idx_d;
  logic                     fc_valid_q, fc_valid_d;
  logic signed [DATA_W-1:0] fc_data_q, fc_data_d;
  logic [6:0]               fc_index_q, fc_index_d;
  logic                     fc_last_q, fc_last_d;
  logic                     done_q, done_d;
  logic                     map_err_q, map_err_d;
  logic                     ovf_q, ovf_d;

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic                     wr_en;
  logic [6:0]               wr_addr;
  logic signed [DATA_W-1:0] wr_data;

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] s);
    if (RELU != 0 && s[DATA_W-1]) return '0;
    return s;
  endfunction

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    map_d      = map_q;
    rd_idx_d   = rd_idx_q;
    fc_valid_d = fc_valid_q;
    fc_data_d  = fc_data_q;
    fc_index_d = fc_index_q;
    fc_last_d  = fc_last_q;
    done_d     = 1'b0;
    map_err_d  = map_err_q;
    ovf_d      = ovf_q;
    wr_en      = 1'b0;
    wr_addr    = 7'(map_q) * PIX_W7 + pix_q;
    wr_data    = relu(max);
    case (state_q)
      COLLECT: begin
        if (buffer_en) begin
          wr_en = 1'b1;
          if (feature_map_counter != map_q) map_err_d = 1'b1;
          if (pix_q == PIX_LAST) begin
            pix_d = '0;
            if (map_q == MAP_LAST) begin
              map_d    = '0;
              rd_idx_d = '0;
              state_d  = DRAIN;
            end else begin
              map_d = map_q + 4'd1;
            end
          end else begin
            pix_d = pix_q + 7'd1;
          end
        end
      end
      DRAIN: begin
        if (buffer_en) ovf_d = 1'b1;
        // Empty output register loads unconditionally; a full one only on a handshake.
        if (!fc_valid_q || fc_ready) begin
          if (fc_valid_q && fc_last_q) begin
            fc_valid_d = 1'b0;
            fc_last_d  = 1'b0;
            done_d     = 1'b1;
            state_d    = DONE;
          end else begin
            fc_valid_d = 1'b1;
            fc_data_d  = mem_q[rd_idx_q];
            fc_index_d = rd_idx_q;
            fc_last_d  = (rd_idx_q == LAST_IDX);
            rd_idx_d   = rd_idx_q + 7'd1;
          end
        end
      end
      DONE: begin
        if (buffer_en) ovf_d = 1'b1;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge cnn_clk) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      pix_q      <= '0;
      map_q      <= '0;
      rd_idx_q   <= '0;
      fc_valid_q <= 1'b0;
      fc_data_q  <= '0;
      fc_index_q <= '0;
      fc_last_q  <= 1'b0;
      done_q     <= 1'b0;
      map_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      map_q      <= map_d;
      rd_idx_q   <= rd_idx_d;
      fc_valid_q <= fc_valid_d;
      fc_data_q  <= fc_data_d;
      fc_index_q <= fc_index_d;
      fc_last_q  <= fc_last_d;
      done_q     <= done_d;
      map_err_q  <= map_err_d;
      ovf_q      <= ovf_d;
    end
  end

  // Frame buffer is not reset; every entry is rewritten before a drain reads it.
  always_ff @(posedge cnn_clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign fc_valid     = fc_valid_q;
  assign fc_data      = fc_data_q;
  assign fc_index     = fc_index_q;
  assign fc_last      = fc_last_q;
  assign collect_done = done_q;
  assign map_err      = map_err_q;
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_pool2_collector.sv
// Directed bench for pool2_collector: one ReLU instance and one raw instance share stimulus.
module tb_pool2_collector;
  logic        cnn_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        buffer_en = 1'b0;
  logic [11:0] max_s = '0;
  logic [3:0]  fmc = '0;
  logic        fc_ready = 1'b0;

  logic        fc_valid, fc_last, collect_done, map_err, overflow_err;
  logic [11:0] fc_data;
  logic [6:0]  fc_index;
  logic        r_valid, r_last, r_done, r_map_err, r_ovf;
  logic [11:0] r_data;
  logic [6:0]  r_index;

  int checks = 0;
  int failures = 0;
  logic [11:0] src [108];

  always #5 cnn_clk = ~cnn_clk;

  pool2_collector dut (
    .cnn_clk(cnn_clk), .rst_n(rst_n), .buffer_en(buffer_en), .max(max_s),
    .feature_map_counter(fmc), .fc_ready(fc_ready), .fc_valid(fc_valid),
    .fc_data(fc_data), .fc_index(fc_index), .fc_last(fc_last),
    .collect_done(collect_done), .map_err(map_err), .overflow_err(overflow_err)
  );

  pool2_collector #(.RELU(0)) dut_raw (
    .cnn_clk(cnn_clk), .rst_n(rst_n), .buffer_en(buffer_en), .max(max_s),
    .feature_map_counter(fmc), .fc_ready(fc_ready), .fc_valid(r_valid),
    .fc_data(r_data), .fc_index(r_index), .fc_last(r_last),
    .collect_done(r_done), .map_err(r_map_err), .overflow_err(r_ovf)
  );

  function automatic logic [11:0] relu_model(input logic [11:0] v);
    return v[11] ? 12'h000 : v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; buffer_en = 1'b0; fc_ready = 1'b0;
    @(posedge cnn_clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({fc_valid, fc_last, collect_done, map_err, overflow_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {fc_valid, fc_last, collect_done, map_err, overflow_err});
    end
    checks++;
    if (fc_data !== 12'h000 || fc_index !== 7'd0) begin
      failures++;
      $display("FAIL reset_data got data=%h idx=%0d exp data=000 idx=0", fc_data, fc_index);
    end
    checks++;
    if ({r_valid, r_last, r_done, r_map_err, r_ovf} !== 5'b0) begin
      failures++;
      $display("FAIL reset_raw_ctrl got=%b exp=00000", {r_valid, r_last, r_done, r_map_err, r_ovf});
    end
  endtask

  task automatic send_frame(input int bad_map);
    for (int i = 0; i < 108; i++) begin
      buffer_en = 1'b1;
      max_s = src[i];
      fmc = 4'(i / 9);
      if (i / 9 == bad_map) fmc = 4'(i / 9 + 1);
      @(posedge cnn_clk); #1;
      checks++;
      if (fc_valid !== 1'b0) begin
        failures++;
        $display("FAIL collect_valid_low strobe=%0d got=%b exp=0", i, fc_valid);
      end
    end
    buffer_en = 1'b0;
  endtask

  task automatic drain(input string name, input bit rand_ready, input int ovf_at,
                       input bit exp_map_err, input bit exp_ovf);
    int got = 0;
    int cyc = 0;
    bit xfer;
    while (got < 108) begin
      if (cyc > 3000) begin
        failures++;
        $display("FAIL %s_timeout got=%0d transfers exp=108", name, got);
        break;
      end
      checks++;
      if (fc_valid !== (cyc != 0)) begin
        failures++;
        $display("FAIL %s_valid cyc=%0d got=%b exp=%b", name, cyc, fc_valid, cyc != 0);
      end
      if (fc_valid === 1'b1) begin
        checks++;
        if (fc_index !== 7'(got) || fc_data !== relu_model(src[got]) || fc_last !== (got == 107)) begin
          failures++;
          $display("FAIL %s_beat got idx=%0d data=%h last=%b exp idx=%0d data=%h last=%b",
                   name, fc_index, fc_data, fc_last, got, relu_model(src[got]), got == 107);
        end
        checks++;
        if (r_index !== 7'(got) || r_data !== src[got]) begin
          failures++;
          $display("FAIL %s_raw_beat got idx=%0d data=%h exp idx=%0d data=%h",
                   name, r_index, r_data, got, src[got]);
        end
      end
      fc_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (fc_valid === 1'b1 && got == ovf_at) begin
        buffer_en = 1'b1;
        max_s = 12'h123;
      end
      xfer = (fc_valid === 1'b1) && fc_ready;
      @(posedge cnn_clk); #1;
      buffer_en = 1'b0;
      cyc++;
      if (xfer) got++;
    end
    checks++;
    if (fc_valid !== 1'b0 || collect_done !== 1'b1 || fc_last !== 1'b0) begin
      failures++;
      $display("FAIL %s_end got valid=%b done=%b last=%b exp valid=0 done=1 last=0",
               name, fc_valid, collect_done, fc_last);
    end
    @(posedge cnn_clk); #1;
    checks++;
    if (collect_done !== 1'b0 || fc_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse got done=%b valid=%b exp done=0 valid=0",
               name, collect_done, fc_valid);
    end
    checks++;
    if (map_err !== exp_map_err || overflow_err !== exp_ovf) begin
      failures++;
      $display("FAIL %s_errors got map=%b ovf=%b exp map=%b ovf=%b",
               name, map_err, overflow_err, exp_map_err, exp_ovf);
    end
    fc_ready = 1'b1;
  endtask

  task automatic fill_pattern(input logic [11:0] offset);
    for (int i = 0; i < 108; i++) src[i] = 12'((i / 9) * 16 + (i % 9)) + offset;
  endtask

  task automatic test_basic_frame();
    fill_pattern(12'h000);
    send_frame(-1);
    drain("basic", 1'b0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_relu();
    for (int i = 0; i < 108; i++) src[i] = 12'(i);
    src[0] = 12'hF80; src[1] = 12'h07F; src[2] = 12'h000;
    src[53] = 12'hFFF; src[107] = 12'h800;
    send_frame(-1);
    drain("relu", 1'b0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    fill_pattern(12'h020);
    send_frame(-1);
    drain("stall", 1'b1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_map_err();
    fill_pattern(12'h000);
    send_frame(4);
    checks++;
    if (map_err !== 1'b1 || overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL map_err_set got map=%b ovf=%b exp map=1 ovf=0", map_err, overflow_err);
    end
    drain("map_err", 1'b0, -1, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    fill_pattern(12'h040);
    send_frame(-1);
    drain("overflow", 1'b0, 2, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    fill_pattern(12'h400);
    send_frame(-1);
    drain("second_frame", 1'b0, -1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 50; i++) begin
      buffer_en = 1'b1; max_s = 12'h5A5; fmc = 4'(i / 9);
      @(posedge cnn_clk); #1;
    end
    buffer_en = 1'b0;
    test_reset();
    fc_ready = 1'b1;
    fill_pattern(12'h300);
    send_frame(-1);
    drain("mid_reset", 1'b0, -1, 1'b0, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog global time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge cnn_clk);
    #1;
    test_reset();
    fc_ready = 1'b1;
    test_basic_frame();
    test_relu();
    test_stall();
    test_map_err();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
